// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: op codes, opcodes, FSM states and decode record.
// Pure declarations, no timing or flow control.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] ALU_ADD  = 6'd0;
    localparam logic [OP_W-1:0] ALU_SLL  = 6'd1;
    localparam logic [OP_W-1:0] ALU_SLT  = 6'd2;
    localparam logic [OP_W-1:0] ALU_SLTU = 6'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 6'd4;
    localparam logic [OP_W-1:0] ALU_SRL  = 6'd5;
    localparam logic [OP_W-1:0] ALU_OR   = 6'd6;
    localparam logic [OP_W-1:0] ALU_AND  = 6'd7;
    localparam logic [OP_W-1:0] ALU_SRA  = 6'd8;
    localparam logic [OP_W-1:0] ALU_SUB  = 6'd9;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        EXE  = 2'd2,
        WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            is_shift;
        logic            zero_rv1;
        logic            illegal;
    } dec_t;

    // Base op for a funct3 value; funct7 refinements are applied by the decoder.
    function automatic logic [OP_W-1:0] f3_to_op(input logic [2:0] f3);
        logic [OP_W-1:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Issue-controller bundle: instruction handshake, regfile read/write ports, ALU operand bus.
// master = issue controller, slave = instruction source / regfile / ALU side.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic            instr_ready;
    logic [4:0]      rf_rs1;
    logic [4:0]      rf_rs2;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [OP_W-1:0] alu_op;
    logic [XLEN-1:0] alu_rv1;
    logic [XLEN-1:0] alu_rv2;
    logic [XLEN-1:0] alu_rvout;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic            done;
    logic            illegal;

    modport master (
        input  instr, instr_valid, rf_rd1, rf_rd2, alu_rvout,
        output instr_ready, rf_rs1, rf_rs2, alu_op, alu_rv1, alu_rv2,
               rf_we, rf_wa, rf_wd, done, illegal
    );

    modport slave (
        output instr, instr_valid, rf_rd1, rf_rd2, alu_rvout,
        input  instr_ready, rf_rs1, rf_rs2, alu_op, alu_rv1, alu_rv2,
               rf_we, rf_wa, rf_wd, done, illegal
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I OP/OP-IMM decode to ALU op, immediate and flags; LUI under ALU_ISSUE_LUI_EN.
// Zero latency, no flow control.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output dec_t            dec
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign f3            = instr[14:12];
    assign f7            = instr[31:25];
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    always_comb begin
        dec          = '0;
        dec.op       = ALU_ADD;
        dec.imm      = {{20{instr[31]}}, instr[31:20]};
        dec.illegal  = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec.illegal  = 1'b0;
                dec.op       = f3_to_op(f3);
                dec.is_shift = (f3 == 3'b001) || (f3 == 3'b101);
                if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000)      dec.op = ALU_SUB;
                    else if (f3 == 3'b101) dec.op = ALU_SRA;
                    else                   dec.illegal = 1'b1;
                end else if (f7 != 7'b0000000) begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                dec.illegal = 1'b0;
                dec.use_imm = 1'b1;
                dec.op      = f3_to_op(f3);
                // funct7 only qualifies the shift forms; other immediates own those bits
                if (f3 == 3'b001) begin
                    dec.is_shift = 1'b1;
                    if (f7 != 7'b0000000) dec.illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    dec.is_shift = 1'b1;
                    if (f7 == 7'b0100000)      dec.op = ALU_SRA;
                    else if (f7 != 7'b0000000) dec.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
`ifdef ALU_ISSUE_LUI_EN
                dec.illegal  = 1'b0;
                dec.use_imm  = 1'b1;
                dec.zero_rv1 = 1'b1;
                dec.imm      = {instr[31:12], 12'b0};
`else
                dec.illegal  = 1'b1;
`endif
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// RV32I ALU issue sequencer: decode, operand read, ALU drive, regfile writeback (LUI via ALU_ISSUE_LUI_EN).
// Latency: accept at edge N -> rf_we/done in cycle N+3 (illegal: done in N+2); one instruction per 4 cycles.
// Backpressure: instr_ready only in IDLE; the source holds instr/instr_valid until accepted.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    alu_issue_ctrl_if.master  bus
);

    state_t          state_q,   state_d;
    logic [XLEN-1:0] instr_q,   instr_d;
    logic [OP_W-1:0] alu_op_q,  alu_op_d;
    logic [XLEN-1:0] alu_rv1_q, alu_rv1_d;
    logic [XLEN-1:0] alu_rv2_q, alu_rv2_d;
    logic [XLEN-1:0] res_q,     res_d;
    logic            illegal_q, illegal_d;

    dec_t            dec;
    logic [XLEN-1:0] rv2_sel;
    logic            in_wb;

    alu_op_decode u_dec (
        .instr (instr_q),
        .dec   (dec)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        alu_op_d  = alu_op_q;
        alu_rv1_d = alu_rv1_q;
        alu_rv2_d = alu_rv2_q;
        res_d     = res_q;
        illegal_d = illegal_q;
        rv2_sel   = dec.use_imm ? dec.imm : bus.rf_rd2;

        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    instr_d   = bus.instr;
                    illegal_d = 1'b0;
                    state_d   = DEC;
                end
            end
            DEC: begin
                illegal_d = dec.illegal;
                if (dec.illegal) begin
                    state_d = WB;
                end else begin
                    // The ALU shifts by all of rv2, so only the 5-bit amount may reach it
                    alu_op_d  = dec.op;
                    alu_rv1_d = dec.zero_rv1 ? '0 : bus.rf_rd1;
                    alu_rv2_d = dec.is_shift ? {27'b0, rv2_sel[4:0]} : rv2_sel;
                    state_d   = EXE;
                end
            end
            EXE: begin
                res_d   = bus.alu_rvout;
                state_d = WB;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            alu_op_q  <= ALU_ADD;
            alu_rv1_q <= '0;
            alu_rv2_q <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            alu_op_q  <= alu_op_d;
            alu_rv1_q <= alu_rv1_d;
            alu_rv2_q <= alu_rv2_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_wb           = (state_q == WB);
    assign bus.instr_ready = (state_q == IDLE);
    assign bus.rf_rs1      = instr_q[19:15];
    assign bus.rf_rs2      = instr_q[24:20];
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_rv1     = alu_rv1_q;
    assign bus.alu_rv2     = alu_rv2_q;
    assign bus.rf_we       = in_wb && !illegal_q && (instr_q[11:7] != 5'd0);
    assign bus.rf_wa       = in_wb ? instr_q[11:7] : 5'd0;
    assign bus.rf_wd       = in_wb ? res_q : '0;
    assign bus.done        = in_wb;
    assign bus.illegal     = in_wb && illegal_q;

endmodule
